pad_input_conditioner: RTL
==========================

// Module: pad_input_conditioner
// PURPOSE
// - Receive-side counterpart of the output pad path: conditions N asynchronous pad input
//   values before they reach core logic (GPIO, external interrupts, wake-up pins).
// - Per bit: 2-flop synchronizer, then a runtime-programmable debounce/glitch filter, then
//   single-cycle rise/fall event pulses.
// - Sits between the pad ring (input value from each pad cell) and the GPIO/interrupt
//   controllers in the always-on domain.
// PARAMETERS
// - NPADS      default 8   number of conditioned pad inputs
// - CNT_W      default 8   debounce counter width; max threshold 2**CNT_W-1
// - RESET_VAL  default 1'b0  reset value of sync stages and filtered output
//   (the same value for all bits)
// PORTS
// - clk_i            in   1         system clock
// - rst_ni           in   1         asynchronous reset, active low
// - pad_in_i         in   NPADS     raw pad input values (asynchronous)
// - en_i             in   NPADS     per-bit filter enable
// - threshold_i      in   CNT_W     debounce threshold T (shared by all bits, quasi-static)
// - pad_out_o        out  NPADS     filtered, synchronous pad value
// - rise_o           out  NPADS     1-cycle pulse on filtered 0->1
// - fall_o           out  NPADS     1-cycle pulse on filtered 1->0
// - edge_status_o    out  NPADS     sticky edge flags (see CONFIGURATION)
// - status_clr_i     in   NPADS     per-bit clear of edge_status_o
// BEHAVIOUR
// - Reset values:
//   - sync stages and pad_out_o = RESET_VAL
//   - counters, rise_o, fall_o and edge_status_o = 0
//   - Reset release generates no edge pulses.
// - Synchronizer: 2 flops per bit (s0 -> s1); s1 is the synchronized value.
// - Filter, per bit, with Teff = (T==0) ? 1 : T:
//   - s1 == pad_out_o: cnt <= 0.
//   - s1 != pad_out_o and cnt >= Teff-1: pad_out_o <= s1 and cnt <= 0.
//   - Otherwise: cnt <= cnt+1. Saturating; it never wraps.
// - Latency: a clean pad step reaches pad_out_o 2+Teff cycles after the sampling edge.
// - Glitches: a pulse on s1 shorter than Teff cycles is fully suppressed and cnt returns to 0.
// - Threshold changes mid-count: compare against the current threshold_i. If cnt already
//   >= Teff-1, pad_out_o updates on the next clock. There is no reset of the count.
// - en_i[k]=0: cnt cleared and pad_out_o[k] held. Sync flops keep running.
//   - rise_o[k]/fall_o[k] stay 0 while disabled.
//   - On re-enable, filtering resumes from the held value. A differing s1 still needs Teff
//     cycles.
// - Edges:
//   - rise_o[k]=1 for exactly the one cycle in which pad_out_o[k] first shows 1 after being 0.
//   - fall_o[k] is symmetric.
//   - rise_o and fall_o are both registered and mutually exclusive.
// - Reset mid-operation: all state returns to the reset values immediately (asynchronously).
//   Partial counts are discarded.
// CONFIGURATION
// - Macro PAD_IN_EDGE_STATUS_EN, defined:
//   - edge_status_o[k] is set on the cycle after rise_o[k]|fall_o[k].
//   - status_clr_i[k]=1 clears it on the next clock.
//   - If set and clear coincide, set wins.
// - Macro PAD_IN_EDGE_STATUS_EN, undefined:
//   - edge_status_o is tied to 0 and status_clr_i is ignored.
//   - The port list is identical in both builds.
// STRUCTURE
// - Package pad_input_pkg:
//   - localparam SYNC_STAGES = 2
//   - typedef enum logic {PAD_IN_STABLE, PAD_IN_PENDING} pad_in_state_e
//     (state = PENDING iff cnt != 0)
// - Sub-module pad_input_filter_bit:
//   - One instance per bit, generated NPADS times.
//   - Contains the synchronizer, counter, filtered flop, edge detect and the optional sticky
//     flag.
//   - The top level only fans out threshold_i.
// TESTING
// - T=4, pad_in_i[0] 0->1 held -> pad_out_o[0]=1 exactly 6 cycles later;
//   rise_o[0]=1 for 1 cycle; no fall_o.
// - T=4, 3-cycle high glitch on pad_in_i[1] -> pad_out_o[1] stays 0;
//   rise_o/fall_o stay 0; cnt back to 0.
// - T=0 and T=1 -> identical behaviour, 3-cycle pad-to-output latency;
//   T=255 -> output changes after 257 stable cycles (saturation check).
// - en_i[2]=0 while pad_in_i[2] toggles 0->1 -> output held at 0, no pulses;
//   en_i[2]=1 -> pad_out_o[2]=1 after T more cycles, one rise_o[2].
// - PAD_IN_EDGE_STATUS_EN: fall_o[3] pulse -> edge_status_o[3]=1 next cycle;
//   status_clr_i[3] with a coincident edge -> stays 1; clear alone -> 0.
//   Without the macro -> always 0.
// - Assert rst_ni low mid-count (cnt=2, T=4) -> outputs at reset values immediately;
//   after release no rise/fall pulse until a full new qualification.

Source files
------------

// File: rtl/pad_input_pkg.sv
// Shared constants and types for the pad input conditioner.
package pad_input_pkg;

   localparam int unsigned SYNC_STAGES = 2;

   typedef enum logic {
      PAD_IN_STABLE,
      PAD_IN_PENDING
   } pad_in_state_e;

endpackage : pad_input_pkg

// File: rtl/pad_input_filter_bit.sv
// One pad bit: synchronizer, debounce filter, edge pulses and optional sticky edge flag.
// The sticky flag is built only when PAD_IN_EDGE_STATUS_EN is defined.
module pad_input_filter_bit
   import pad_input_pkg::*;
#(
   parameter int unsigned CNT_W     = 8,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             pad_i,
   input  logic             en_i,
   input  logic [CNT_W-1:0] threshold_i,
   input  logic             status_clr_i,
   output logic             pad_o,
   output logic             rise_o,
   output logic             fall_o,
   output logic             edge_status_o
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s1;
   pad_in_state_e          state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       teff_m1;
   logic                   out_q, out_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   assign s1 = sync_q[SYNC_STAGES-1];

   // T==0 behaves as T==1, so the last count before update is max(T,1)-1.
   assign teff_m1 = (threshold_i == '0) ? '0 : threshold_i - CNT_W'(1);

   always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], pad_i};
      state_d = state_q;
      cnt_d   = cnt_q;
      out_d   = out_q;

      if (!en_i || (s1 == out_q)) begin
         state_d = PAD_IN_STABLE;
         cnt_d   = '0;
      end else begin
         unique case (state_q)
            PAD_IN_STABLE: begin
               if (teff_m1 == '0) begin
                  out_d = s1;
               end else begin
                  state_d = PAD_IN_PENDING;
                  cnt_d   = CNT_W'(1);
               end
            end
            PAD_IN_PENDING: begin
               if (cnt_q >= teff_m1) begin
                  out_d   = s1;
                  state_d = PAD_IN_STABLE;
                  cnt_d   = '0;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         endcase
      end

      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q  <= {SYNC_STAGES{RESET_VAL}};
         state_q <= PAD_IN_STABLE;
         cnt_q   <= '0;
         out_q   <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign pad_o  = out_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;

`ifdef PAD_IN_EDGE_STATUS_EN
   logic status_q, status_d;

   // A new edge outranks a coincident clear.
   always_comb begin
      status_d = (rise_q | fall_q) | (status_q & ~status_clr_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         status_q <= 1'b0;
      end else begin
         status_q <= status_d;
      end
   end

   assign edge_status_o = status_q;
`else
   logic unused_status_clr;
   assign unused_status_clr = status_clr_i;
   assign edge_status_o     = 1'b0;
`endif

endmodule : pad_input_filter_bit

// File: rtl/pad_input_conditioner.sv
// Conditions NPADS asynchronous pad inputs: sync, debounce, edge pulses, sticky flags.
// Sticky edge flags are present only when PAD_IN_EDGE_STATUS_EN is defined.
module pad_input_conditioner
   import pad_input_pkg::*;
#(
   parameter int unsigned NPADS     = 8,
   parameter int unsigned CNT_W     = 8,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [NPADS-1:0] pad_in_i,
   input  logic [NPADS-1:0] en_i,
   input  logic [CNT_W-1:0] threshold_i,
   output logic [NPADS-1:0] pad_out_o,
   output logic [NPADS-1:0] rise_o,
   output logic [NPADS-1:0] fall_o,
   output logic [NPADS-1:0] edge_status_o,
   input  logic [NPADS-1:0] status_clr_i
);

   for (genvar k = 0; k < NPADS; k++) begin : g_bit
      pad_input_filter_bit #(
         .CNT_W     (CNT_W),
         .RESET_VAL (RESET_VAL)
      ) u_bit (
         .clk_i         (clk_i),
         .rst_ni        (rst_ni),
         .pad_i         (pad_in_i[k]),
         .en_i          (en_i[k]),
         .threshold_i   (threshold_i),
         .status_clr_i  (status_clr_i[k]),
         .pad_o         (pad_out_o[k]),
         .rise_o        (rise_o[k]),
         .fall_o        (fall_o[k]),
         .edge_status_o (edge_status_o[k])
      );
   end

endmodule : pad_input_conditioner
